// File: rtl/rv32i_types.sv
// Shared types for the retired register alias table: default sizing, the
// per-lane retire record, and the flush handshake state encoding.
package rv32i_types;

  localparam int RRAT_SS        = 2;
  localparam int RRAT_ARCH_REGS = 32;
  localparam int RRAT_PHYS_REGS = 64;
  localparam int RRAT_AW        = $clog2(RRAT_ARCH_REGS);
  localparam int RRAT_PW        = $clog2(RRAT_PHYS_REGS);

  typedef struct packed {
    logic               valid;
    logic [RRAT_AW-1:0] rd_arch;
    logic [RRAT_PW-1:0] rd_phys;
  } retire_lane_t;

  typedef enum logic {
    RRAT_IDLE = 1'b0,
    RRAT_HOLD = 1'b1
  } rrat_state_e;

endpackage

// File: rtl/rrat_bundle_resolve.sv
// Same-destination priority resolution inside one retire bundle: which older
// lane supplies each writer's superseded preg, and which lane owns each arch reg.
module rrat_bundle_resolve #(
  parameter int SS        = 2,
  parameter int ARCH_REGS = 32,
  parameter int AW        = $clog2(ARCH_REGS),
  parameter int LW        = (SS > 1) ? $clog2(SS) : 1
) (
  input  logic [SS-1:0]                 accept_i,
  input  logic [SS-1:0][AW-1:0]         rd_arch_i,
  output logic [SS-1:0]                 writer_o,
  output logic [SS-1:0]                 fwd_hit_o,
  output logic [SS-1:0][LW-1:0]         fwd_lane_o,
  output logic [ARCH_REGS-1:0]          final_hit_o,
  output logic [ARCH_REGS-1:0][LW-1:0]  final_lane_o
);

  always_comb begin
    for (int i = 0; i < SS; i++) begin
      writer_o[i] = accept_i[i] && (rd_arch_i[i] != '0);
    end
  end

  // Later matches overwrite earlier ones, so the youngest older writer wins.
  always_comb begin
    fwd_hit_o  = '0;
    fwd_lane_o = '0;
    for (int i = 0; i < SS; i++) begin
      for (int j = 0; j < i; j++) begin
        if (writer_o[j] && (rd_arch_i[j] == rd_arch_i[i])) begin
          fwd_hit_o[i]  = 1'b1;
          fwd_lane_o[i] = LW'(j);
        end
      end
    end
  end

  always_comb begin
    final_hit_o  = '0;
    final_lane_o = '0;
    for (int r = 1; r < ARCH_REGS; r++) begin
      for (int i = 0; i < SS; i++) begin
        if (writer_o[i] && (rd_arch_i[i] == AW'(r))) begin
          final_hit_o[r]  = 1'b1;
          final_lane_o[r] = LW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/retired_rat_ss.sv
// Committed arch-to-physical map with per-lane free-list return and a
// flush handshake that exposes the frozen map to the speculative RAT.
module retired_rat_ss
  import rv32i_types::*;
#(
  parameter int SS        = RRAT_SS,
  parameter int ARCH_REGS = RRAT_ARCH_REGS,
  parameter int PHYS_REGS = RRAT_PHYS_REGS,
  parameter int AW        = $clog2(ARCH_REGS),
  parameter int PW        = $clog2(PHYS_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SS-1:0]                 retire_valid_i,
  input  logic [SS-1:0][AW-1:0]         retire_rd_arch_i,
  input  logic [SS-1:0][PW-1:0]         retire_rd_phys_i,
  output logic                          retire_ready_o,
  output logic [SS-1:0]                 free_valid_o,
  output logic [SS-1:0][PW-1:0]         free_preg_o,
  input  logic                          flush_req_i,
  input  logic                          flush_ack_i,
  output logic [ARCH_REGS-1:0][PW-1:0]  snapshot_o,
  output logic                          snapshot_valid_o,
  output logic [31:0]                   retire_count_o
);

  localparam int LW = (SS > 1) ? $clog2(SS) : 1;

  rrat_state_e                   state_q, state_d;
  logic [ARCH_REGS-1:0][PW-1:0]  map_q, map_d;
  logic [SS-1:0]                 freeValid_q, freeValid_d;
  logic [SS-1:0][PW-1:0]         freePreg_q, freePreg_d;
  logic [31:0]                   retireCount_q, retireCount_d;

  logic [SS-1:0]                 accepted;
  logic [SS-1:0]                 writer;
  logic [SS-1:0]                 fwdHit;
  logic [SS-1:0][LW-1:0]         fwdLane;
  logic [ARCH_REGS-1:0]          finalHit;
  logic [ARCH_REGS-1:0][LW-1:0]  finalLane;
  logic                          dupWriter;

  assign accepted = retire_valid_i & {SS{retire_ready_o}};

  rrat_bundle_resolve #(
    .SS        (SS),
    .ARCH_REGS (ARCH_REGS),
    .AW        (AW),
    .LW        (LW)
  ) u_resolve (
    .accept_i     (accepted),
    .rd_arch_i    (retire_rd_arch_i),
    .writer_o     (writer),
    .fwd_hit_o    (fwdHit),
    .fwd_lane_o   (fwdLane),
    .final_hit_o  (finalHit),
    .final_lane_o (finalLane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RRAT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RRAT_IDLE: if (flush_req_i) state_d = RRAT_HOLD;
      RRAT_HOLD: if (flush_ack_i) state_d = RRAT_IDLE;
      default:   state_d = RRAT_IDLE;
    endcase
  end

  always_comb begin
    retire_ready_o   = (state_q == RRAT_IDLE);
    snapshot_valid_o = (state_q == RRAT_HOLD);
  end

  // A writer's superseded preg comes from an older same-rd lane if one exists.
  always_comb begin
    freeValid_d = writer;
    freePreg_d  = freePreg_q;
    for (int i = 0; i < SS; i++) begin
      if (writer[i]) begin
        freePreg_d[i] = fwdHit[i] ? retire_rd_phys_i[fwdLane[i]]
                                  : map_q[retire_rd_arch_i[i]];
      end
    end
  end

  always_comb begin
    map_d = map_q;
    for (int r = 0; r < ARCH_REGS; r++) begin
      if (finalHit[r]) map_d[r] = retire_rd_phys_i[finalLane[r]];
    end
  end

  always_comb begin
    retireCount_d = retireCount_q;
    for (int i = 0; i < SS; i++) begin
      retireCount_d = retireCount_d + 32'(accepted[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ARCH_REGS; r++) map_q[r] <= PW'(r);
      freeValid_q   <= '0;
      freePreg_q    <= '0;
      retireCount_q <= '0;
    end else begin
      map_q         <= map_d;
      freeValid_q   <= freeValid_d;
      freePreg_q    <= freePreg_d;
      retireCount_q <= retireCount_d;
    end
  end

  assign free_valid_o   = freeValid_q;
  assign free_preg_o    = freePreg_q;
  assign snapshot_o     = map_q;
  assign retire_count_o = retireCount_q;

  always_comb begin
    dupWriter = 1'b0;
    for (int i = 0; i < SS; i++) begin
      for (int j = 0; j < i; j++) begin
        if (writer[i] && writer[j] &&
            (retire_rd_arch_i[i] == retire_rd_arch_i[j]) &&
            (retire_rd_phys_i[i] == retire_rd_phys_i[j])) begin
          dupWriter = 1'b1;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) !dupWriter)
    else $error("retired_rat_ss: two writers share rd and rd_phys in one bundle");

endmodule
